enigma_uart_tx: RTL and testbench

//   Output side of the enigma core. Accepts 5-bit cipher letter codes (0=A..25=Z)

---
 rtl/enigma_uart_tx.sv | 146 ++++++++++++++
 tb/tb_enigma_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_uart_tx.sv
// Letter-code FIFO plus UART 8N1 transmitter; codes 0..25 go out as 'A'..'Z', others as '?'.
// Define GROUP5_EN to insert a space frame after every fifth letter.
module enigma_uart_tx #(
  parameter int unsigned CLK_DIV    = 87,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TimerLoad = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TimerOne  = TW'(1);
  localparam logic [AW:0]   PtrOne    = (AW+1)'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [4:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic            full, empty, push, pop;
  logic [4:0]      head;
  logic [7:0]      head_ascii;

`ifdef GROUP5_EN
  logic [2:0]      grp_q, grp_d;
  logic            space_q, space_d;
`endif

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign char_ready = !full;
  assign push       = char_valid && !full;
  assign pop        = (state_q == StIdle) && !empty;
  assign busy       = (state_q != StIdle) || !empty;
  assign head       = mem[rd_ptr_q[AW-1:0]];
  assign head_ascii = (head < 5'd26) ? (8'h41 + {3'b000, head}) : 8'h3F;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= char_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= StIdle;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef GROUP5_EN
      grp_q    <= '0;
      space_q  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef GROUP5_EN
      grp_q   <= grp_d;
      space_q <= space_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx      = 1'b1;
`ifdef GROUP5_EN
    grp_d   = grp_q;
    space_d = space_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          shift_d = head_ascii;
          timer_d = TimerLoad;
          state_d = StStart;
`ifdef GROUP5_EN
          space_d = 1'b0;
`endif
        end
      end
      StStart: begin
        tx = 1'b0;
        if (timer_q == '0) begin
          timer_d = TimerLoad;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      StData: begin
        tx = shift_q[0];
        if (timer_q == '0) begin
          timer_d = TimerLoad;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      StStop: begin
        if (timer_q == '0) begin
          state_d = StIdle;
`ifdef GROUP5_EN
          // Fifth letter just finished: chain a space frame with no idle gap.
          if (!space_q) begin
            if (grp_q == 3'd4) begin
              grp_d   = 3'd0;
              space_d = 1'b1;
              shift_d = 8'h20;
              timer_d = TimerLoad;
              state_d = StStart;
            end else begin
              grp_d = grp_q + 3'd1;
            end
          end
`endif
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_enigma_uart_tx.sv
// Bench for enigma_uart_tx: frame-level reference model compared every cycle, UART decoder,
// and directed literal checks. Honours GROUP5_EN in the same way as the design.
module tb_enigma_uart_tx;
  localparam int CD    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] char_in = '0;
  logic       char_valid = 1'b0;
  logic       char_ready, tx, busy;

  enigma_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [7:0] to_ascii(input int c);
    return (c < 26) ? 8'(8'h41 + c) : 8'h3F;
  endfunction

  // Reference model: a queue of codes and the position within the current 10-bit frame.
  int         mq[$];
  logic [7:0] m_byte = '0;
  int         m_cyc = 0;
  bit         m_act = 0;
  bit         m_sp  = 0;
  int         m_grp = 0;

  function automatic logic model_tx();
    if (!m_act)         return 1'b1;
    if (m_cyc < CD)     return 1'b0;
    if (m_cyc < 9 * CD) return m_byte[(m_cyc - CD) / CD];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_act = 0; m_cyc = 0; m_sp = 0; m_grp = 0;
    end else begin
      bit do_push;
      int code;
      do_push = char_valid && (mq.size() < DEPTH);
      code    = int'(char_in);
      if (!m_act) begin
        if (mq.size() > 0) begin
          m_byte = to_ascii(mq.pop_front());
          m_act = 1; m_cyc = 0; m_sp = 0;
        end
      end else begin
        m_cyc++;
        if (m_cyc == 10 * CD) begin
          m_act = 0;
`ifdef GROUP5_EN
          if (!m_sp) begin
            if (m_grp == 4) begin
              m_grp = 0; m_act = 1; m_cyc = 0; m_byte = 8'h20; m_sp = 1;
            end else begin
              m_grp++;
            end
          end
`endif
        end
      end
      if (do_push) mq.push_back(code);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("model tx", int'(tx), int'(model_tx()));
      check("model busy", int'(busy), int'(m_act || mq.size() > 0));
      check("model char_ready", int'(char_ready), int'(mq.size() < DEPTH));
    end
  end

  // UART decoder sampling mid-bit.
  byte        rxq[$];
  logic [7:0] rx_sh = '0;
  int         rx_off = 0;
  bit         rx_act = 0;

  initial forever begin
    @(negedge clk or posedge rst);
    if (rst) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act = 1; rx_off = 0;
      end
    end else begin
      rx_off++;
      if (rx_off % CD == CD / 2 && rx_off / CD >= 1 && rx_off / CD <= 8)
        rx_sh[rx_off / CD - 1] = tx;
      if (rx_off == 10 * CD - 1) begin
        rxq.push_back(rx_sh);
        rx_act = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    char_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rxq.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle"}, int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_str(input string name, input string exp);
    string got;
    got = "";
    foreach (rxq[i]) got = $sformatf("%s%c", got, rxq[i]);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
  endtask

  // Holds char_valid high walking codes first..last; blk = accepts before char_ready first drops.
  task automatic send_range(input string name, input int first, input int last, output int blk);
    int  idx, cnt, guard;
    bit  r;
    idx = first; cnt = 0; guard = 0; blk = -1;
    char_valid = 1'b1;
    while (idx <= last && guard < 5000) begin
      char_in = 5'(idx);
      @(negedge clk);
      r = char_ready;
      if (!r && blk < 0) blk = cnt;
      @(posedge clk);
      #1;
      if (r) begin
        idx++;
        cnt++;
      end
      guard++;
    end
    char_valid = 1'b0;
    check({name, " all accepted"}, idx, last + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         blk;
    logic [7:0] h;
    string      exp_s;

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset tx", int'(tx), 1);
    check("reset busy", int'(busy), 0);
    check("reset char_ready", int'(char_ready), 1);

    // Single letter 'H': start bit, LSB-first data, stop bit
    char_in = 5'd7; char_valid = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0;
    @(posedge clk);
    h = 8'h48;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("H wave cycle %0d", i), int'(tx),
            (i < 4) ? 0 : (i < 36) ? int'(h[(i - 4) / 4]) : 1);
    end
    check("H busy last stop cycle", int'(busy), 1);
    @(negedge clk);
    check("H busy after 40", int'(busy), 0);
    repeat (2) @(negedge clk);
    check_str("single H", "H");

    // Out-of-range code
    do_reset();
    char_in = 5'd27; char_valid = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0;
    wait_idle("oor");
    check_str("oor code 27", "?");

    // Backpressure with codes 0..5
    do_reset();
    send_range("bp", 0, 5, blk);
    check("bp ready drop after 4 or 5", int'(blk == 4 || blk == 5), 1);
    wait_idle("bp");
`ifdef GROUP5_EN
    exp_s = "ABCDE F";
`else
    exp_s = "ABCDEF";
`endif
    check_str("bp order", exp_s);

    // Push in the IDLE pop cycle with one entry queued
    do_reset();
    @(negedge clk);
    char_in = 5'd1; char_valid = 1'b1;
    @(posedge clk);
    #1 char_in = 5'd2;
    @(posedge clk);
    #1 char_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 char_in = 5'd3; char_valid = 1'b1;
    @(posedge clk);
    #1 char_in = 5'd4;
    @(posedge clk);
    #1 char_in = 5'd5;
    @(posedge clk);
    #1 char_in = 5'd6;
    @(negedge clk);
    check("pp ready before 4th", int'(char_ready), 1);
    @(posedge clk);
    #1 char_valid = 1'b0;
    @(negedge clk);
    check("pp full after 4", int'(char_ready), 0);
    wait_idle("pp");
`ifdef GROUP5_EN
    exp_s = "BCDEF G";
`else
    exp_s = "BCDEFG";
`endif
    check_str("pp order", exp_s);

    // Reset during DATA bit 3 of 'A', with 'B' queued
    do_reset();
    @(negedge clk);
    char_in = 5'd0; char_valid = 1'b1;
    @(posedge clk);
    #1 char_in = 5'd1;
    @(posedge clk);
    #1 char_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("mid bit3 low", int'(tx), 0);
    #1 rst = 1'b1;
    #1;
    check("mid rst tx", int'(tx), 1);
    check("mid rst busy", int'(busy), 0);
    check("mid rst ready", int'(char_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rxq.delete();
    @(negedge clk);
    check("mid post busy", int'(busy), 0);
    check("mid post ready", int'(char_ready), 1);
    repeat (50) @(negedge clk);
    check("mid fifo lost", rxq.size(), 0);

    // Ten letters: grouping
    do_reset();
    send_range("grp", 0, 9, blk);
    wait_idle("grp");
`ifdef GROUP5_EN
    exp_s = "ABCDE FGHIJ ";
`else
    exp_s = "ABCDEFGHIJ";
`endif
    check_str("grp stream", exp_s);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
